// File: rtl/vecmac_accum.sv
// vecmac_accum: accumulates lane-sum beats into saturating dot-product results behind a 2-entry output FIFO
module vecmac_accum #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [17:0]      in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic             busy,
  output logic             ovf_err,
  output logic             unexp_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, h_acc_q, h_acc_d, t_acc_q, t_acc_d, nacc;
  logic [ACC_W:0] nxt;
  logic sat_q, sat_d, h_sat_q, h_sat_d, t_sat_q, t_sat_d;
  logic hv_q, hv_d, tv_q, tv_d, ovf_q, ovf_d, unexp_q, unexp_d;
  logic start, run, beat, last, clr, pop, nsat, drop, h_new, h_tail, t_new;
  always_comb begin
    start = cfg_start & ~cfg_stop;
    run = state_q == RUN;
    beat = run & in_valid & ~start;
    nxt = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
    nsat = sat_q | nxt[ACC_W];
    nacc = nsat ? '1 : nxt[ACC_W-1:0];
    last = beat & (cnt_q == len_q - LEN_W'(1));
    clr = start | cfg_stop | last;
    pop = hv_q & out_ready;
    state_d = start ? RUN : cfg_stop ? IDLE : state_q;
    len_d = start ? (cfg_len == '0 ? LEN_W'(1) : cfg_len) : len_q;
    acc_d = clr ? '0 : beat ? nacc : acc_q;
    cnt_d = clr ? '0 : beat ? cnt_q + LEN_W'(1) : cnt_q;
    sat_d = ~clr & (beat ? nsat : sat_q);
    // a completion into a full FIFO survives only if the head leaves the same cycle
    drop = last & hv_q & tv_q & ~pop;
    ovf_d = ~start & (ovf_q | drop);
    unexp_d = ~start & (unexp_q | (~run & in_valid));
    h_new = last & (~hv_q | (pop & ~tv_q));
    h_tail = pop & tv_q;
    t_new = last & hv_q & (pop ? tv_q : ~tv_q);
    hv_d = last | (pop ? tv_q : hv_q);
    tv_d = last ? (pop ? tv_q : hv_q) : (pop ? 1'b0 : tv_q);
    h_acc_d = h_new ? nacc : h_tail ? t_acc_q : h_acc_q;
    h_sat_d = h_new ? nsat : h_tail ? t_sat_q : h_sat_q;
    t_acc_d = t_new ? nacc : t_acc_q;
    t_sat_d = t_new ? nsat : t_sat_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
      hv_q <= 1'b0;
      tv_q <= 1'b0;
      h_acc_q <= '0;
      h_sat_q <= 1'b0;
      t_acc_q <= '0;
      t_sat_q <= 1'b0;
      ovf_q <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
      hv_q <= hv_d;
      tv_q <= tv_d;
      h_acc_q <= h_acc_d;
      h_sat_q <= h_sat_d;
      t_acc_q <= t_acc_d;
      t_sat_q <= t_sat_d;
      ovf_q <= ovf_d;
      unexp_q <= unexp_d;
    end
  end
  assign out_valid = hv_q;
  assign out_acc = h_acc_q;
  assign out_sat = h_sat_q;
  assign busy = state_q == RUN;
  assign ovf_err = ovf_q;
  assign unexp_err = unexp_q;
endmodule

// File: doc/vecmac_accum.md
Name: vecmac_accum

Overview:
- Consumer end of the 4-lane int8 dot-product pipeline. Receives the per-beat 18-bit unsigned lane sums (`out_valid`/`out_sum` from the multiplier tree).
- Accumulates a programmed number of beats into one wide dot-product result, then restarts automatically for the next vector.
- Completed results are buffered in a 2-entry output FIFO with a valid/ready handshake toward the writeback logic.
- The multiplier pipeline has no backpressure. This block never stalls its input; it drops results and flags them when the FIFO is full.

Parameters:
- ACC_W, 32, accumulator and result width in bits (≥ 19).
- LEN_W, 16, width of the beat-count configuration.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  one-cycle pulse: latch `cfg_len`, clear state and flags, enter RUN.
- cfg_stop  in  1  one-cycle pulse: abort the partial vector, return to IDLE.
- cfg_len  in  LEN_W  beats (4-element chunks) per vector; sampled only on `cfg_start`.
- in_valid  in  1  lane-sum beat valid (from multiplier `out_valid`).
- in_sum  in  18  unsigned lane sum, 0..260100.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  downstream accepts the head when `out_valid & out_ready`.
- out_acc  out  ACC_W  head result value.
- out_sat  out  1  head result saturated.
- busy  out  1  state == RUN.
- ovf_err  out  1  sticky: a completed result was dropped because the FIFO was full.
- unexp_err  out  1  sticky: `in_valid` seen while IDLE.

Behaviour:
- Reset (async, `rst_n` low): state = IDLE, acc = 0, beat_cnt = 0, FIFO empty. Outputs: `out_valid`=0, `out_acc`=0, `out_sat`=0, `busy`=0, `ovf_err`=0, `unexp_err`=0. Reset mid-vector discards everything, including FIFO contents.
- IDLE:
  - `in_valid` is ignored and sets `unexp_err`.
  - `cfg_start` latches len = (`cfg_len`==0 ? 1 : `cfg_len`), clears acc, beat_cnt, `ovf_err` and `unexp_err`, and moves to RUN next cycle.
  - `cfg_start` does NOT flush the FIFO.
- RUN, per `in_valid` beat:
  - nxt = acc + zero-extended `in_sum`, computed ACC_W+1 wide.
  - If nxt ≥ 2^ACC_W: acc ← 2^ACC_W−1 and the per-vector sat flag is set. Once saturated, acc holds that value for the rest of the vector.
  - beat_cnt increments.
- Final beat (beat_cnt == len−1 with `in_valid`):
  - Result {nxt (saturated), sat} is pushed to the FIFO.
  - acc, beat_cnt and sat are cleared in the same edge, so the next beat starts a new vector with zero bubble.
  - State stays RUN.
- Latency: `out_valid` rises the cycle after the final beat's edge when the FIFO was empty. `out_acc` is registered from the FIFO head; no combinational path from `in_*` to `out_*`.
- FIFO (2 entries):
  - Pop on `out_valid & out_ready`.
  - Push when full, with no pop that cycle: the result is dropped and `ovf_err` is set. FIFO contents are unchanged.
  - Push when full with a simultaneous pop: the push is accepted and nothing is dropped.
  - Push and pop with 1 entry: occupancy stays 1, order is preserved.
  - `out_acc`/`out_sat` hold stable while `out_valid` is high and `out_ready` is low.
- `cfg_stop` in RUN: partial acc/beat_cnt/sat are discarded and the next state is IDLE. A final-beat push in the same cycle still completes (push wins), then IDLE.
- `cfg_stop` in IDLE: no effect.
- `cfg_start` in RUN: restart. Partial vector discarded, new len latched, flags cleared. An `in_valid` beat in that cycle is discarded.
- `cfg_start` and `cfg_stop` together: `cfg_stop` wins.
- `busy` is registered and equals (state == RUN).

Test Plan:
- len=4, four beats {1000, 2000, 3000, 4000}, `out_ready`=1 → `out_valid` one cycle after the 4th beat; `out_acc`=10000, `out_sat`=0; `busy`=1 throughout.
- len=2, continuous beats of 260100, `out_ready`=0 for 8 beats → exactly two entries of 520200 held stable; `ovf_err`=1 after the 3rd completion. Raising `out_ready` drains both entries in order; then `out_valid`=0.
- ACC_W=19, len=3, beats 260100 ×3 → `out_acc`=524287, `out_sat`=1. The next vector {5, 6, 7} gives 18 with `out_sat`=0.
- `cfg_len`=0 then single beats {7, 9} → two results, 7 and 9 (len treated as 1).
- len=4, two beats {100, 200}, then `cfg_stop` → no result, `busy`=0. A following `in_valid` sets `unexp_err`. Then `cfg_start` (len=1) clears `unexp_err`, and beat 55 → result 55.
- FIFO full, `out_ready`=1, and a final beat completing in the same cycle → no drop, `ovf_err` stays 0, three results emerge in order. Assert `rst_n` mid-vector → all outputs 0 immediately (async).
